// File: rtl/mtf_decoder.sv
// ============================================================================
// mtf_decoder : move-to-front token decoder with a most-recent-first table
// Rev 1.0
// ============================================================================
`default_nettype none

module mtf_decoder #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic              clear_in,
  input  logic              tok_valid_in,
  output logic              tok_ready_out,
  input  logic              tok_hit_in,
  input  logic [IDX_W-1:0]  tok_idx_in,
  input  logic [DATA_W-1:0] tok_lit_in,
  output logic              out_valid_out,
  input  logic              out_ready_in,
  output logic [DATA_W-1:0] out_data_out,
  output logic [IDX_W:0]    fill_out,
  output logic              err_out
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] table_q [DEPTH];
  logic [DATA_W-1:0] table_d [DEPTH];
  logic [CNT_W-1:0]  fill_q;
  logic [CNT_W-1:0]  fill_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              err_q;

  logic              accept;
  logic              match_found;
  logic [IDX_W-1:0]  match_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic              idx_ok;
  logic              is_move;
  logic              is_bad;
  logic [IDX_W-1:0]  shift_lim;
  logic [DATA_W-1:0] sel_val;
  logic [DATA_W-1:0] new_val;

  assign tok_ready_out = !out_valid_q || out_ready_in;
  assign accept        = tok_valid_in && tok_ready_out && !clear_in;

  // Scan from the tail so the lowest-numbered matching entry wins.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < fill_q) && (table_q[i] == tok_lit_in)) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    idx_ok  = ({1'b0, tok_idx_in} < fill_q);
    sel_idx = tok_hit_in ? tok_idx_in : match_idx;
    is_move = tok_hit_in ? idx_ok : match_found;
    is_bad  = tok_hit_in && !idx_ok;
    // A fresh literal is a move-to-front from one past the tail.
    shift_lim = is_move ? sel_idx : IDX_W'(DEPTH - 1);
    sel_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (IDX_W'(i) == sel_idx) begin
        sel_val = table_q[i];
      end
    end
    new_val = is_move ? sel_val : tok_lit_in;
  end

  always_comb begin
    table_d = table_q;
    fill_d  = fill_q;
    if (accept && !is_bad) begin
      table_d[0] = new_val;
      for (int i = 1; i < DEPTH; i++) begin
        if (IDX_W'(i) <= shift_lim) begin
          table_d[i] = table_q[i-1];
        end
      end
      if (!is_move && (fill_q != FULL)) begin
        fill_d = fill_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
      fill_q <= '0;
    end else if (clear_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
      fill_q <= '0;
    end else begin
      table_q <= table_d;
      fill_q  <= fill_d;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else if (clear_in) begin
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (accept && !is_bad) begin
        out_valid_q <= 1'b1;
        out_data_q  <= new_val;
      end else if (out_ready_in) begin
        out_valid_q <= 1'b0;
      end
      if (accept && is_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  assign out_valid_out = out_valid_q;
  assign out_data_out  = out_data_q;
  assign fill_out      = fill_q;
  assign err_out       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mtf_decoder.sv
// ============================================================================
// tb_mtf_decoder : directed vector table plus backpressure / async-reset cases
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mtf_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       tok_valid;
  logic       tok_ready;
  logic       tok_hit;
  logic [1:0] tok_idx;
  logic [7:0] tok_lit;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] fill;
  logic       err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mtf_decoder #(.DATA_W(8), .DEPTH(4)) dut (
    .clk_in        (clk),
    .reset_n_in    (reset_n),
    .clear_in      (clear),
    .tok_valid_in  (tok_valid),
    .tok_ready_out (tok_ready),
    .tok_hit_in    (tok_hit),
    .tok_idx_in    (tok_idx),
    .tok_lit_in    (tok_lit),
    .out_valid_out (out_valid),
    .out_ready_in  (out_ready),
    .out_data_out  (out_data),
    .fill_out      (fill),
    .err_out       (err)
  );

  typedef struct {
    logic       clr;
    logic       vld;
    logic       hit;
    logic [1:0] idx;
    logic [7:0] lit;
    logic       rdy;
    logic       e_trdy;
    logic       e_ov;
    logic [7:0] e_dat;
    logic [2:0] e_fill;
    logic       e_err;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic v, input logic h, input logic [1:0] i,
                       input logic [7:0] l, input logic r);
    clear = c; tok_valid = v; tok_hit = h; tok_idx = i; tok_lit = l; out_ready = r;
  endtask

  logic [7:0] got [$];
  logic [7:0] want [3];

  initial begin
    //          clr vld hit idx lit    rdy  trdy ov  data   fill err
    vecs[0]  = '{0, 1, 0, 0, 8'h11, 1, 1, 1, 8'h11, 1, 0};
    vecs[1]  = '{0, 1, 0, 0, 8'h22, 1, 1, 1, 8'h22, 2, 0};
    vecs[2]  = '{0, 1, 0, 0, 8'h33, 1, 1, 1, 8'h33, 3, 0};
    vecs[3]  = '{0, 1, 1, 2, 8'h00, 1, 1, 1, 8'h11, 3, 0}; // -> [11,33,22]
    vecs[4]  = '{0, 1, 0, 0, 8'h22, 1, 1, 1, 8'h22, 3, 0}; // -> [22,11,33]
    vecs[5]  = '{0, 1, 1, 0, 8'h00, 1, 1, 1, 8'h22, 3, 0};
    vecs[6]  = '{0, 1, 0, 0, 8'h44, 1, 1, 1, 8'h44, 4, 0}; // -> [44,22,11,33]
    vecs[7]  = '{0, 1, 0, 0, 8'h55, 1, 1, 1, 8'h55, 4, 0}; // -> [55,44,22,11]
    vecs[8]  = '{0, 1, 1, 3, 8'h00, 1, 1, 1, 8'h11, 4, 0}; // -> [11,55,44,22]
    vecs[9]  = '{0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 4, 0};
    vecs[10] = '{1, 1, 0, 0, 8'h66, 1, 1, 0, 8'h00, 0, 0};
    vecs[11] = '{0, 1, 0, 0, 8'hAA, 1, 1, 1, 8'hAA, 1, 0};
    vecs[12] = '{0, 1, 0, 0, 8'hBB, 1, 1, 1, 8'hBB, 2, 0}; // -> [BB,AA]
    vecs[13] = '{0, 1, 1, 3, 8'h00, 1, 1, 0, 8'h00, 2, 1};
    vecs[14] = '{0, 1, 1, 1, 8'h00, 1, 1, 1, 8'hAA, 2, 1}; // -> [AA,BB]
    vecs[15] = '{0, 1, 1, 2, 8'h00, 1, 1, 0, 8'h00, 2, 1};
    vecs[16] = '{1, 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0};

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 8'h00, 1);
    step();
    step();
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_data",  32'(out_data),  0);
    check("reset fill",      32'(fill),      0);
    check("reset err",       32'(err),       0);
    check("reset tok_ready", 32'(tok_ready), 1);
    reset_n = 1'b1;
    step();

    for (int n = 0; n < NVEC; n++) begin
      drive(vecs[n].clr, vecs[n].vld, vecs[n].hit, vecs[n].idx, vecs[n].lit, vecs[n].rdy);
      step();
      check($sformatf("v%0d tok_ready", n), 32'(tok_ready), 32'(vecs[n].e_trdy));
      check($sformatf("v%0d out_valid", n), 32'(out_valid), 32'(vecs[n].e_ov));
      if (vecs[n].e_ov)
        check($sformatf("v%0d out_data", n), 32'(out_data), 32'(vecs[n].e_dat));
      check($sformatf("v%0d fill", n), 32'(fill), 32'(vecs[n].e_fill));
      check($sformatf("v%0d err", n), 32'(err), 32'(vecs[n].e_err));
    end

    // Backpressure: output stalls for three cycles with a token waiting.
    want[0] = 8'h01; want[1] = 8'h02; want[2] = 8'h03;
    drive(0, 1, 0, 0, 8'h01, 0);
    step();
    check("bp first out_valid", 32'(out_valid), 1);
    drive(0, 1, 0, 0, 8'h02, 0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp stall%0d tok_ready", c), 32'(tok_ready), 0);
      if (out_valid && out_ready) got.push_back(out_data);
      step();
      check($sformatf("bp stall%0d out_data", c), 32'(out_data), 32'h01);
      check($sformatf("bp stall%0d out_valid", c), 32'(out_valid), 1);
    end
    drive(0, 1, 0, 0, 8'h02, 1);
    if (out_valid && out_ready) got.push_back(out_data);
    step();
    drive(0, 1, 0, 0, 8'h03, 1);
    if (out_valid && out_ready) got.push_back(out_data);
    step();
    drive(0, 0, 0, 0, 8'h00, 1);
    if (out_valid && out_ready) got.push_back(out_data);
    step();
    check("bp drained out_valid", 32'(out_valid), 0);
    check("bp count", 32'(got.size()), 3);
    for (int k = 0; k < 3; k++)
      if (k < got.size()) check($sformatf("bp order%0d", k), 32'(got[k]), 32'(want[k]));
    check("bp fill", 32'(fill), 3);

    // Asynchronous reset with an output in flight.
    drive(0, 1, 0, 0, 8'h77, 0);
    step();
    check("pre-reset out_valid", 32'(out_valid), 1);
    drive(0, 0, 0, 0, 8'h00, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(out_valid), 0);
    check("async reset fill",      32'(fill),      0);
    check("async reset out_data",  32'(out_data),  0);
    check("async reset tok_ready", 32'(tok_ready), 1);
    step();
    reset_n = 1'b1;
    drive(0, 1, 1, 0, 8'h00, 1);
    step();
    check("post-reset idx0 err", 32'(err), 1);
    check("post-reset idx0 out_valid", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mtf_decoder.md
Name: mtf_decoder

Overview:
- Move-to-front (MTF) decoder, the receive-side counterpart of the MRU value tracker.
- Consumes a token stream of either "hit at index k" or "literal value".
- Reconstructs the original data stream while keeping an identical DEPTH-entry most-recent-first table.
- Sits downstream of the channel/link and feeds reconstructed bytes to the consumer over valid/ready.

Parameters:
- DATA_W, 8, data and literal width in bits.
- DEPTH, 4, number of table entries (≥2).
- IDX_W, $clog2(DEPTH), token index width (derived, not overridden).

Ports:
- clk_in  input  1  clock, all logic on rising edge.
- reset_n_in  input  1  asynchronous active-low reset.
- clear_in  input  1  synchronous table/pipeline clear, takes priority over token acceptance.
- tok_valid_in  input  1  token valid.
- tok_ready_out  output  1  decoder can accept a token this cycle.
- tok_hit_in  input  1  1 = index token, 0 = literal token.
- tok_idx_in  input  IDX_W  table index, used when tok_hit_in=1.
- tok_lit_in  input  DATA_W  literal value, used when tok_hit_in=0.
- out_valid_out  output  1  decoded data valid.
- out_ready_in  input  1  consumer accepts data.
- out_data_out  output  DATA_W  decoded value.
- fill_out  output  IDX_W+1  number of valid table entries, 0..DEPTH.
- err_out  output  1  sticky: an index token referenced an invalid entry.

Behaviour:
- Reset (async assert, sync release): table entries 0, entry-valid bits 0, fill_out 0, out_valid_out 0, out_data_out 0, err_out 0.
- tok_ready_out = !out_valid_out || out_ready_in. Purely combinational; there is no path from tok_valid_in.
- A token is accepted when tok_valid_in && tok_ready_out && !clear_in.
- Output register: decoded value appears on out_data_out with out_valid_out=1 in the cycle after acceptance (latency 1).
  - Held stable while out_valid_out && !out_ready_in.
  - Cleared (out_valid_out=0) on handshake with no new accept.
- Throughput: one token per cycle when out_ready_in=1.
- Table order: entry 0 = most recent.
- Table lookup is combinational on registered state. A token accepted in cycle n+1 sees the table updated by the token accepted in cycle n.
- Index token, idx < fill:
  - value = table[idx].
  - Entries 0..idx-1 shift down one position; value written to entry 0.
  - Fill unchanged.
- Index token, idx ≥ fill:
  - Token consumed, no output.
  - Table and fill unchanged.
  - err_out set to 1 and held until reset or clear_in.
- Literal token, value matches valid entry j (first match from entry 0):
  - Treated exactly as index token j (move-to-front).
  - Fill unchanged; no duplicate is created.
- Literal token, no match:
  - All entries shift down one; literal written to entry 0.
  - Entry DEPTH-1 is evicted when full.
  - Fill increments, saturating at DEPTH.
- clear_in=1:
  - Next edge clears table, valid bits, fill, out_valid_out and err_out.
  - Any token presented that cycle is not accepted.
- Reset asserted mid-stream: the in-flight output is discarded with no handshake required.

Test Plan:
- Reset, then literals 0x11,0x22,0x33 with out_ready_in=1 → out_data_out 0x11,0x22,0x33 on consecutive cycles, each one cycle after its accept; final table [0x33,0x22,0x11,–], fill_out=3.
- From that state, index token 2 → out 0x11; table [0x11,0x33,0x22]; fill_out=3.
- From [0x11,0x33,0x22], literal 0x22 → out 0x22; table [0x22,0x11,0x33]; fill_out=3.
- Fill to [0x44,0x33,0x22,0x11], then literal 0x55 → out 0x55; table [0x55,0x44,0x33,0x22]; 0x11 evicted; fill_out=4. Then index token 3 → out 0x22.
- Fill=2, index token 3:
  - No out_valid_out pulse; err_out=1 from the next cycle; table unchanged.
  - Then clear_in pulse → err_out=0, fill_out=0.
- Backpressure: out_ready_in=0 for 3 cycles with tokens pending → tok_ready_out=0, out_data_out stable; after release all tokens emerge in order with none lost or duplicated.
- Reset asserted mid-stream with out_valid_out=1 → out_valid_out=0 and fill_out=0 immediately (asynchronously).
